// File: rtl/sys_bus_initiator_if.sv
// sys_bus register-bus interface: one initiator (m) strobes wen/ren, a slave (s)
// answers with ack/err/rdata.
interface sys_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic clk
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wen;
    logic          ren;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;

    modport m (input clk, output addr, output wdata, output wen, output ren,
               input ack, input err, input rdata);
    modport s (input clk, input addr, input wdata, input wen, input ren,
               output ack, output err, output rdata);
endinterface

// File: rtl/sys_bus_initiator.sv
// Single-outstanding sys_bus initiator: command in, one wen/ren strobe out,
// bounded wait for ack, response (data/err/timeout) back on a valid/ready port.
module sys_bus_initiator #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TO = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_tout,
    output logic [1:0]    dbg_state,
    sys_bus_if.m          bus
);
    // Handshake: a transfer happens on a rising clk edge where valid && ready.
    // A source holds valid and its payload stable until that edge; ready may
    // be low arbitrarily long. Both cmd and rsp ports obey this.

    localparam int CW = $clog2(TO + 1);

    if (TO < 1 || TO > 65535) begin : g_bad_to
        $error("sys_bus_initiator: TO must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_d;
    logic          err_d;
    logic          tout_d;
    logic          cmd_rdy_d;
    logic          rsp_vld_d;
    logic          wen_q, wen_d;
    logic          ren_q, ren_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tout  <= 1'b0;
            cmd_rdy   <= 1'b0;
            rsp_vld   <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            rsp_tout  <= tout_d;
            cmd_rdy   <= cmd_rdy_d;
            rsp_vld   <= rsp_vld_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
        tout_d  = rsp_tout;
        unique case (state_q)
            IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    state_d = REQ;
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                end
            end
            REQ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.ack) begin
                    state_d = RSP;
                    rdata_d = wr_q ? '0 : bus.rdata;
                    err_d   = bus.err;
                    tout_d  = 1'b0;
                end else if (cnt_q == CW'(TO - 1)) begin
                    // TO-th WAIT cycle without ack: give up and report.
                    state_d = RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RSP: begin
                if (rsp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state, so they line up with it.
        cmd_rdy_d = (state_d == IDLE);
        rsp_vld_d = (state_d == RSP);
        wen_d     = (state_d == REQ) && wr_d;
        ren_d     = (state_d == REQ) && !wr_d;
    end

    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.wen   = wen_q;
    assign bus.ren   = ren_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_sys_bus_initiator.sv
// Directed bench for sys_bus_initiator against a small registered-ack slave model.
module tb_sys_bus_initiator;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tout;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sys_bus_if #(.AW(32), .DW(32)) bus (.clk(clk));

    sys_bus_initiator #(.AW(32), .DW(32), .TO(TO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tout(rsp_tout), .dbg_state(dbg_state),
        .bus(bus)
    );

    // slave model: 16 words, ack registered one cycle after a strobe
    logic [31:0] mem [0:15];
    logic        mute = 1'b0;
    logic        err_inj = 1'b0;
    logic        force_ack = 1'b0;
    logic        slv_ack;
    logic        slv_err;
    logic [31:0] slv_rdata;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2]    <= 32'h0000_1234;
            slv_ack   <= 1'b0;
            slv_err   <= 1'b0;
            slv_rdata <= 32'h0;
        end else begin
            slv_ack <= (bus.wen || bus.ren) && !mute;
            slv_err <= (bus.wen || bus.ren) && err_inj;
            if (bus.ren) slv_rdata <= mem[bus.addr[5:2]];
            if (bus.wen) mem[bus.addr[5:2]] <= bus.wdata;
        end
    end

    assign bus.ack   = slv_ack | force_ack;
    assign bus.err   = slv_err | force_ack;
    assign bus.rdata = force_ack ? 32'hBAD0_BAD0 : slv_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command, observe it to completion. hold = cycles of rsp_rdy=0
    // after rsp_vld is seen. Cycle k counts from 1 = cycle after accept edge.
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int hold,
                          output logic [31:0] rd, output logic er, output logic to,
                          output int req_at, output int vld_at, output int nstb);
        int   k;
        logic rdy_bad;
        logic stable_bad;
        rd = '0; er = 1'b0; to = 1'b0;
        req_at = -1; vld_at = -1; nstb = 0; rdy_bad = 1'b0; stable_bad = 1'b0;
        @(negedge clk);
        k = 0;
        while (!cmd_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_rdy_wait", {31'd0, cmd_rdy}, 32'd1);
        cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        rsp_rdy = (hold == 0);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0; cmd_addr = 32'hFFFF_FFFC; cmd_wdata = 32'h5555_AAAA;
        for (k = 1; k <= 60 && vld_at < 0; k++) begin
            @(negedge clk);
            if (bus.wen || bus.ren) begin
                nstb++;
                if (req_at < 0) begin
                    req_at = k;
                    check("strobe_addr", bus.addr, a);
                    check("strobe_wen", {31'd0, bus.wen}, {31'd0, wr});
                    check("strobe_ren", {31'd0, bus.ren}, {31'd0, !wr});
                    if (wr) check("strobe_wdata", bus.wdata, d);
                end
            end
            if (cmd_rdy) rdy_bad = 1'b1;
            if (rsp_vld) vld_at = k;
        end
        check("rsp_vld_seen", {31'd0, (vld_at > 0)}, 32'd1);
        check("cmd_rdy_busy", {31'd0, rdy_bad}, 32'd0);
        rd = rsp_rdata; er = rsp_err; to = rsp_tout;
        check("addr_held", bus.addr, a);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_vld || rsp_rdata !== rd || rsp_err !== er || rsp_tout !== to) stable_bad = 1'b1;
            if (cmd_rdy) stable_bad = 1'b1;
            if (bus.wen || bus.ren) nstb++;
        end
        if (hold > 0) check("bp_stable", {31'd0, stable_bad}, 32'd0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("rsp_vld_drop", {31'd0, rsp_vld}, 32'd0);
        check("cmd_rdy_back", {31'd0, cmd_rdy}, 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    logic        to;
    int          req_at;
    int          vld_at;
    int          nstb;
    logic        bad;

    initial begin
        // reset state
        #12;
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        check("rst_strobes", {30'd0, bus.wen, bus.ren}, 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel_cmd_rdy_low", {31'd0, cmd_rdy}, 32'd0);
        @(negedge clk);
        check("rel_cmd_rdy_high", {31'd0, cmd_rdy}, 32'd1);

        // read 0x8 -> 0x1234
        do_txn(1'b0, 32'h8, 32'h0, 0, rd, er, to, req_at, vld_at, nstb);
        check("rd_req_at", req_at, 32'd1);
        check("rd_vld_at", vld_at, 32'd3);
        check("rd_nstb", nstb, 32'd1);
        check("rd_data", rd, 32'h0000_1234);
        check("rd_err", {31'd0, er}, 32'd0);
        check("rd_tout", {31'd0, to}, 32'd0);

        // write 0xDEADBEEF to 0x4, then read it back
        do_txn(1'b1, 32'h4, 32'hDEAD_BEEF, 0, rd, er, to, req_at, vld_at, nstb);
        check("wr_req_at", req_at, 32'd1);
        check("wr_vld_at", vld_at, 32'd3);
        check("wr_nstb", nstb, 32'd1);
        check("wr_rdata", rd, 32'd0);
        check("wr_err", {31'd0, er}, 32'd0);
        do_txn(1'b0, 32'h4, 32'h0, 0, rd, er, to, req_at, vld_at, nstb);
        check("rb_data", rd, 32'hDEAD_BEEF);

        // timeout: slave never acks
        mute = 1'b1;
        do_txn(1'b0, 32'h8, 32'h0, 0, rd, er, to, req_at, vld_at, nstb);
        check("to_req_at", req_at, 32'd1);
        check("to_vld_at", vld_at, 32'd1 + 32'd1 + TO);
        check("to_nstb", nstb, 32'd1);
        check("to_rdata", rd, 32'd0);
        check("to_err", {31'd0, er}, 32'd1);
        check("to_tout", {31'd0, to}, 32'd1);
        mute = 1'b0;
        // late ack two cycles after the response went out
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_vld || bus.wen || bus.ren || !cmd_rdy) bad = 1'b1;
            @(negedge clk);
        end
        check("late_ack_ignored", {31'd0, bad}, 32'd0);
        do_txn(1'b0, 32'h8, 32'h0, 0, rd, er, to, req_at, vld_at, nstb);
        check("post_to_vld_at", vld_at, 32'd3);
        check("post_to_data", rd, 32'h0000_1234);
        check("post_to_tout", {31'd0, to}, 32'd0);

        // backpressure: rsp_rdy low for 10 cycles
        do_txn(1'b0, 32'h4, 32'h0, 10, rd, er, to, req_at, vld_at, nstb);
        check("bp_data", rd, 32'hDEAD_BEEF);
        check("bp_nstb", nstb, 32'd1);

        // slave error
        err_inj = 1'b1;
        do_txn(1'b0, 32'h8, 32'h0, 0, rd, er, to, req_at, vld_at, nstb);
        check("serr_err", {31'd0, er}, 32'd1);
        check("serr_tout", {31'd0, to}, 32'd0);
        check("serr_data", rd, 32'h0000_1234);
        err_inj = 1'b0;

        // reset in the middle of WAIT
        mute = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("mid_state_wait", {30'd0, dbg_state}, 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("mr_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("mr_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        check("mr_strobes", {30'd0, bus.wen, bus.ren}, 32'd0);
        check("mr_addr", bus.addr, 32'd0);
        check("mr_wdata", bus.wdata, 32'd0);
        check("mr_rdata", rsp_rdata, 32'd0);
        check("mr_err_tout", {30'd0, rsp_err, rsp_tout}, 32'd0);
        mute = 1'b0;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        force_ack = 1'b1;
        #1;
        check("mr_rel_cmd_rdy_low", {31'd0, cmd_rdy}, 32'd0);
        @(negedge clk);
        check("mr_rel_cmd_rdy_high", {31'd0, cmd_rdy}, 32'd1);
        force_ack = 1'b0;
        @(negedge clk);
        check("mr_stale_ack", {31'd0, rsp_vld}, 32'd0);
        check("mr_state_idle", {30'd0, dbg_state}, 32'd0);
        do_txn(1'b0, 32'h8, 32'h0, 0, rd, er, to, req_at, vld_at, nstb);
        check("mr_next_data", rd, 32'h0000_1234);
        check("mr_next_vld_at", vld_at, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
